// File: rtl/gate_debounce_pkg.sv
// Shared definitions for the gate input debouncer: per-channel FSM encoding and default debounce length.
package gate_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } dbc_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: optional 2-flop synchronizer (GATE_DEBOUNCE_SYNC_EN), mismatch counter, clean register.
// Latency N+2 edges with the synchronizer, N without; upd is a registered pulse coincident with a clean change.
module debounce_ch
  import gate_debounce_pkg::*;
#(
  parameter int unsigned N = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic upd
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic          synced;
  dbc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          upd_q, upd_d;

`ifdef GATE_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], raw};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= sync_d;
  end

  assign synced = sync_q[1];
`else
  assign synced = raw;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    upd_d   = 1'b0;
    case (state_q)
      STABLE: begin
        if (synced != clean_q) begin
          cnt_d   = CW'(1);
          state_d = COUNTING;
        end else begin
          cnt_d = '0;
        end
      end
      COUNTING: begin
        if (synced == clean_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CW'(N - 1)) begin
          // This edge is the Nth consecutive mismatch: commit the new level.
          clean_d = ~clean_q;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      upd_q   <= upd_d;
    end
  end

  assign clean = clean_q;
  assign upd   = upd_q;

endmodule

// File: rtl/gate_input_debounce.sv
// Debounces the two bouncy gate switches a_raw/b_raw into clean a/b plus a single chg pulse per update edge.
// Synchronizer inserted when GATE_DEBOUNCE_SYNC_EN is defined; free-running, no handshake.
module gate_input_debounce
  import gate_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic chg
);

  logic upd_a, upd_b;

  debounce_ch #(.N(DEBOUNCE_CYCLES)) u_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (a_raw),
    .clean (a),
    .upd   (upd_a)
  );

  debounce_ch #(.N(DEBOUNCE_CYCLES)) u_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_raw),
    .clean (b),
    .upd   (upd_b)
  );

  // Both upd flops are registered, so a simultaneous update yields one pulse.
  assign chg = upd_a | upd_b;

endmodule

// File: doc/gate_input_debounce.md
GATE_INPUT_DEBOUNCE -- requirements
Module: gate_input_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive mismatch cycles (N) required before a clean output follows its input; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port a_raw  input  1  asynchronous bouncy switch for gate input a.
REQ-005 SHALL have port b_raw  input  1  asynchronous bouncy switch for gate input b.
REQ-006 SHALL have port a  output  1  debounced level, registered, driving the downstream gate's a input.
REQ-007 SHALL have port b  output  1  debounced level, registered, driving the downstream gate's b input.
REQ-008 SHALL have port chg  output  1  one-cycle pulse marking that a or b changed on that edge.

Function
REQ-009 SHALL process each channel independently with identical logic: synchronizer, then counter, then clean register.
REQ-010 SHALL run per channel a 2-state FSM (STABLE, COUNTING) plus a counter of width clog2(N)+1.
REQ-011 SHALL, in STABLE with synced input equal to the clean output, hold the counter at 0.
REQ-012 SHALL, in STABLE with synced input not equal to the clean output, set the counter to 1 and enter COUNTING.
REQ-013 SHALL, in COUNTING with a mismatch and counter < N, increment the counter.
REQ-014 SHALL, in COUNTING with a mismatch on the edge where the counter would reach N, invert the clean output, clear the counter and return to STABLE.
REQ-015 SHALL, in COUNTING with the synced input again equal to the clean output (a bounce), clear the counter and return to STABLE without changing the output.
REQ-016 SHALL keep the counter from ever exceeding N or wrapping.
REQ-017 SHALL make the input-to-output latency, with the synchronizer compiled in, exactly N+2 rising edges; the edge that first samples the new raw level counts as edge 1.
REQ-018 SHALL assert chg high for exactly the one cycle after any edge on which a or b updates.
REQ-019 SHALL produce a single one-cycle chg pulse, not two, when a and b update on the same edge.
REQ-020 SHALL run continuously with no handshake; the downstream gate consumes a and b directly.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, clear to 0: synchronizer flops, counters, a, b and chg; both FSMs SHALL enter STABLE.
REQ-022 SHALL, when rst is asserted mid-COUNTING, discard the count; after release, debouncing restarts from a=b=0 and the full latency applies again.
REQ-023 SHALL let rst take priority over every other event on the same edge.

Configuration
REQ-024 SHALL, with macro GATE_DEBOUNCE_SYNC_EN defined, insert a 2-flop synchronizer on a_raw and b_raw, giving a latency of N+2.
REQ-025 SHALL, with GATE_DEBOUNCE_SYNC_EN undefined, feed a_raw and b_raw straight to the comparison, giving a latency of exactly N; all other behaviour is unchanged.

Structure
REQ-026 SHALL place in a shared package gate_debounce_pkg:
- the FSM state encoding (STABLE=0, COUNTING=1);
- the default DEBOUNCE_CYCLES constant.
REQ-027 SHALL implement one channel as sub-module debounce_ch (ports: clk, rst, raw, clean, upd), instantiated twice; the top ORs the two upd signals into chg.

Verification
REQ-028 SHALL cover a clean step with N=4 and the sync enabled: reset, then a_raw 0->1 held -> a=1 and one chg pulse on edge 6; b stays 0.
REQ-029 SHALL cover a bounce: with N=4, a_raw high for 3 cycles then low -> a stays 0 and chg is never asserted.
REQ-030 SHALL cover a simultaneous change: a_raw and b_raw rise on the same cycle, N=4 -> a=b=1 on the same edge with exactly one chg pulse.
REQ-031 SHALL cover reset mid-count: rst pulsed on the third mismatch cycle -> a=0, counter 0; a_raw still high -> a=1 six edges after rst deasserts.
REQ-032 SHALL cover the macro undefined: N=4, a_raw 0->1 -> a=1 on edge 4.
REQ-033 SHALL cover a falling edge and the boundary N=2: a=1, then a_raw 1->0 -> a=0 on edge 4 with sync; the counter never exceeds 2.
